// File: rtl/cv32e40p_glitch_pkg.sv
// Shared types and default parameters for the glitch-sensor alarm controller.
package cv32e40p_glitch_pkg;

  // Controller states: quiet, warned (interrupt raised), locked down (core halted)
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WARN     = 2'd1,
    LOCKDOWN = 2'd2
  } glitch_state_e;

  localparam int unsigned N_SENSORS_DEFAULT = 4;
  localparam int unsigned THRESHOLD_DEFAULT = 3;
  localparam int unsigned WINDOW_DEFAULT    = 256;

  // Width of the per-window alarm count; it saturates at 255
  localparam int unsigned WIN_CNT_W = 8;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and add in the same
// cycle load the add value, which is how a counter restarts at a new value.
module cv32e40p_sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ADD_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [ADD_W-1:0] add_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam int unsigned SUM_W = ((WIDTH > ADD_W) ? WIDTH : ADD_W) + 1;
  localparam logic [SUM_W-1:0] MAX_VAL = {{(SUM_W - WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic [SUM_W-1:0] sum;

  // Add to the (optionally cleared) base and clamp at the all-ones value
  always_comb begin
    sum      = (clr_i ? '0 : SUM_W'(cnt_reg)) + SUM_W'(add_i);
    cnt_next = (sum > MAX_VAL) ? '1 : sum[WIDTH-1:0];
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/cv32e40p_glitch_alarm_ctrl.sv
// Aggregates delay-line glitch sensor pulses into a warning interrupt and,
// when too many alarms land inside one observation window, a sticky lockdown.
module cv32e40p_glitch_alarm_ctrl
  import cv32e40p_glitch_pkg::*;
#(
  parameter int unsigned N_SENSORS = N_SENSORS_DEFAULT,
  parameter int unsigned THRESHOLD = THRESHOLD_DEFAULT,
  parameter int unsigned WINDOW    = WINDOW_DEFAULT,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SENSORS-1:0] alarm_i,
  input  logic                 enable_i,
  input  logic                 clear_req_i,
  output logic                 clear_ack_o,
  output logic                 irq_o,
  output logic                 halt_o,
  output logic [N_SENSORS-1:0] sensor_status_o,
  output logic [CNT_W-1:0]     alarm_count_o
);

  localparam int unsigned HIT_W = $clog2(N_SENSORS + 1);
  localparam int unsigned WIN_W = $clog2(WINDOW + 1);

  glitch_state_e state_reg, state_next;

  logic [N_SENSORS-1:0] accepted;
  logic [HIT_W-1:0]     hits;
  logic [WIN_W-1:0]     win_cyc;
  logic [WIN_CNT_W-1:0] win_cnt;
  logic [WIN_CNT_W:0]   win_sum;
  logic                 win_restart;
  logic                 win_clr;
  logic [0:0]           win_cyc_add;
  logic [HIT_W-1:0]     win_cnt_add;
  logic                 clear_take;

  logic                 irq_reg, halt_reg, clear_ack_reg;
  logic [N_SENSORS-1:0] status_reg;

  generate
    for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_accept
      assign accepted[gi] = alarm_i[gi] & enable_i;
    end
  endgenerate

  // Number of sensors firing this cycle
  always_comb begin
    hits = '0;
    for (int i = 0; i < N_SENSORS; i++) hits = hits + HIT_W'(accepted[i]);
  end

  // A clear is only taken on an alarm-free cycle, never in lockdown, and not
  // while the previous acknowledge is still visible (the requester may not
  // have dropped its level request yet).
  assign clear_take = (state_reg != LOCKDOWN) && clear_req_i &&
                      (hits == '0) && !clear_ack_reg;

  // Window state restarts when idle/expired (counter 0) or when it reaches WINDOW
  assign win_restart = (win_cyc == '0) || (win_cyc == WIN_W'(WINDOW));
  // Unclamped updated window count; the clamp cannot change a >= THRESHOLD test
  assign win_sum = (win_restart ? '0 : {1'b0, win_cnt}) + (WIN_CNT_W + 1)'(hits);

  // Window counter controls; frozen in lockdown, zeroed by an accepted clear
  always_comb begin
    win_clr     = 1'b0;
    win_cyc_add = 1'b0;
    win_cnt_add = '0;
    if (clear_take) begin
      win_clr = 1'b1;
    end else if (state_reg != LOCKDOWN) begin
      win_clr     = win_restart;
      win_cyc_add = win_restart ? (hits != '0) : 1'b1;
      win_cnt_add = hits;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, WARN: begin
        if (clear_take) begin
          state_next = IDLE;
        end else if (hits != '0) begin
          state_next = (win_sum >= (WIN_CNT_W + 1)'(THRESHOLD)) ? LOCKDOWN : WARN;
        end
      end
      LOCKDOWN: state_next = LOCKDOWN;
      default:  state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Registered outputs, derived from the next state so they track the FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_reg       <= 1'b0;
      halt_reg      <= 1'b0;
      clear_ack_reg <= 1'b0;
      status_reg    <= '0;
    end else begin
      irq_reg       <= (state_next != IDLE);
      halt_reg      <= (state_next == LOCKDOWN);
      clear_ack_reg <= clear_take;
      status_reg    <= clear_take ? '0 : (status_reg | accepted);
    end
  end

  cv32e40p_sat_counter #(.WIDTH(WIN_W), .ADD_W(1)) u_win_cyc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (win_clr),
    .add_i (win_cyc_add),
    .cnt_o (win_cyc)
  );

  cv32e40p_sat_counter #(.WIDTH(WIN_CNT_W), .ADD_W(HIT_W)) u_win_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (win_clr),
    .add_i (win_cnt_add),
    .cnt_o (win_cnt)
  );

  cv32e40p_sat_counter #(.WIDTH(CNT_W), .ADD_W(HIT_W)) u_life_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .add_i (hits),
    .cnt_o (alarm_count_o)
  );

  assign irq_o           = irq_reg;
  assign halt_o          = halt_reg;
  assign clear_ack_o     = clear_ack_reg;
  assign sensor_status_o = status_reg;

endmodule
